// File: rtl/mem_trace_recorder.sv
`timescale 1ns/1ps
// mem_trace_recorder
// Passive monitor for NUM_CH req/gnt/rvalid memory ports. Each completed
// transaction becomes a record {channel, grant timestamp, latency, we, addr,
// data}. Per-channel staging registers feed a shared FIFO through a
// round-robin arbiter; the FIFO is read out over a valid/ready port.
// Ports:
//   clk_i, rst_ni          clock, async active-low reset
//   trace_en_i             capture enable (completions always recorded)
//   ch_req_i/ch_gnt_i      per-channel request/grant
//   ch_we_i/ch_addr_i/ch_wdata_i   request attributes, packed per channel
//   ch_rvalid_i/ch_rdata_i response valid/data, packed per channel
//   tr_valid_o/tr_ready_i  FIFO head handshake
//   tr_ch_o..tr_data_o     FIFO head record fields (zero when empty)
//   fill_o                 FIFO occupancy 0..DEPTH
//   drop_cnt_o             saturating count of lost records
//   proto_err_o            sticky protocol violation flag
module mem_trace_recorder #(
    parameter int NUM_CH     = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int TS_WIDTH   = 16,
    parameter int LAT_WIDTH  = 8
) (
    input  logic                                        clk_i,
    input  logic                                        rst_ni,
    input  logic                                        trace_en_i,
    input  logic [NUM_CH-1:0]                           ch_req_i,
    input  logic [NUM_CH-1:0]                           ch_gnt_i,
    input  logic [NUM_CH-1:0]                           ch_we_i,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]                ch_addr_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0]                ch_wdata_i,
    input  logic [NUM_CH-1:0]                           ch_rvalid_i,
    input  logic [NUM_CH*DATA_WIDTH-1:0]                ch_rdata_i,
    output logic                                        tr_valid_o,
    input  logic                                        tr_ready_i,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] tr_ch_o,
    output logic [TS_WIDTH-1:0]                         tr_ts_o,
    output logic [LAT_WIDTH-1:0]                        tr_lat_o,
    output logic                                        tr_we_o,
    output logic [ADDR_WIDTH-1:0]                       tr_addr_o,
    output logic [DATA_WIDTH-1:0]                       tr_data_o,
    output logic [$clog2(DEPTH):0]                      fill_o,
    output logic [15:0]                                 drop_cnt_o,
    output logic                                        proto_err_o
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [TS_WIDTH-1:0]   ts;
        logic [LAT_WIDTH-1:0]  lat;
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } rec_t;

    typedef struct packed {
        logic [CH_W-1:0] ch;
        rec_t            rec;
    } fent_t;

    logic [TS_WIDTH-1:0]   r_ts;
    logic [NUM_CH-1:0]     r_out, r_we, r_stg_vld;
    logic [ADDR_WIDTH-1:0] r_addr  [NUM_CH];
    logic [DATA_WIDTH-1:0] r_wdata [NUM_CH];
    logic [TS_WIDTH-1:0]   r_gts   [NUM_CH];
    logic [LAT_WIDTH-1:0]  r_lat   [NUM_CH];
    rec_t                  r_stg   [NUM_CH];
    fent_t                 r_mem   [DEPTH];
    logic [PTR_W-1:0]      r_wp, r_rp;
    logic [PTR_W:0]        r_cnt;
    logic [CH_W-1:0]       r_rr;
    logic [15:0]           r_drop;
    logic                  r_perr;

    logic                  w_win_vld, w_push, w_pop;
    logic [CH_W-1:0]       w_win;
    int                    w_dist, w_best;
    logic [NUM_CH-1:0]     w_drain, w_cmpl, w_drop, w_cap, w_perr;
    logic [4:0]            w_ndrop;
    logic [16:0]           w_drop_sum;
    fent_t                 w_head;

    // Round-robin: pick the valid staging entry closest at-or-after r_rr.
    always_comb begin
        w_win     = '0;
        w_win_vld = 1'b0;
        w_best    = NUM_CH;
        w_dist    = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (r_stg_vld[c]) begin
                w_dist = (c >= int'(r_rr)) ? c - int'(r_rr) : c + NUM_CH - int'(r_rr);
                if (w_dist < w_best) begin
                    w_best    = w_dist;
                    w_win     = CH_W'(c);
                    w_win_vld = 1'b1;
                end
            end
        end
    end

    assign w_pop  = (r_cnt != '0) && tr_ready_i;
    // A full FIFO still accepts a push when the head is popped this cycle.
    assign w_push = w_win_vld && ((r_cnt != (PTR_W+1)'(DEPTH)) || w_pop);

    always_comb begin
        w_drain = '0;
        w_cmpl  = '0;
        w_drop  = '0;
        w_cap   = '0;
        w_perr  = '0;
        w_ndrop = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            w_drain[c] = w_push && (w_win == CH_W'(c));
            w_cmpl[c]  = ch_rvalid_i[c] && r_out[c];
            w_drop[c]  = w_cmpl[c] && r_stg_vld[c] && !w_drain[c];
            // A same-cycle completion frees the slot for a new capture.
            w_cap[c]   = ch_req_i[c] && ch_gnt_i[c] && trace_en_i &&
                         (!r_out[c] || ch_rvalid_i[c]);
            w_perr[c]  = (ch_rvalid_i[c] && !r_out[c]) ||
                         (ch_req_i[c] && ch_gnt_i[c] && r_out[c] && !ch_rvalid_i[c]);
            w_ndrop    = w_ndrop + 5'(w_drop[c]);
        end
    end

    assign w_drop_sum = {1'b0, r_drop} + 17'(w_ndrop);

    // Per-channel outstanding tracking and staging.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_out     <= '0;
            r_we      <= '0;
            r_stg_vld <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_addr[c]  <= '0;
                r_wdata[c] <= '0;
                r_gts[c]   <= '0;
                r_lat[c]   <= '0;
                r_stg[c]   <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (w_cap[c]) begin
                    r_out[c]   <= 1'b1;
                    r_we[c]    <= ch_we_i[c];
                    r_addr[c]  <= ch_addr_i[c*ADDR_WIDTH +: ADDR_WIDTH];
                    r_wdata[c] <= ch_wdata_i[c*DATA_WIDTH +: DATA_WIDTH];
                    r_gts[c]   <= r_ts;
                    // Counter reads k in the cycle k after the grant.
                    r_lat[c]   <= LAT_WIDTH'(1);
                end else if (w_cmpl[c]) begin
                    r_out[c]   <= 1'b0;
                end else if (r_out[c] && (r_lat[c] != '1)) begin
                    r_lat[c]   <= r_lat[c] + 1'b1;
                end

                if (w_cmpl[c] && !w_drop[c]) begin
                    r_stg_vld[c] <= 1'b1;
                    r_stg[c]     <= '{ts:   r_gts[c],
                                      lat:  r_lat[c],
                                      we:   r_we[c],
                                      addr: r_addr[c],
                                      data: r_we[c] ? r_wdata[c]
                                                    : ch_rdata_i[c*DATA_WIDTH +: DATA_WIDTH]};
                end else if (w_drain[c]) begin
                    r_stg_vld[c] <= 1'b0;
                end
            end
        end
    end

    // Timestamp, FIFO pointers, arbiter pointer and status counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ts   <= '0;
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
            r_rr   <= '0;
            r_drop <= '0;
            r_perr <= 1'b0;
        end else begin
            r_ts <= r_ts + 1'b1;
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
                r_rr <= (w_win == CH_W'(NUM_CH-1)) ? '0 : w_win + 1'b1;
            end
            if (w_pop) r_rp <= r_rp + 1'b1;
            if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
            else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
            r_drop <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            if (|w_perr) r_perr <= 1'b1;
        end
    end

    // Storage needs no reset: reads are masked by the occupancy count.
    always_ff @(posedge clk_i) begin
        if (w_push) r_mem[r_wp] <= '{ch: w_win, rec: r_stg[w_win]};
    end

    assign w_head      = (r_cnt != '0) ? r_mem[r_rp] : '0;
    assign tr_valid_o  = (r_cnt != '0);
    assign tr_ch_o     = w_head.ch;
    assign tr_ts_o     = w_head.rec.ts;
    assign tr_lat_o    = w_head.rec.lat;
    assign tr_we_o     = w_head.rec.we;
    assign tr_addr_o   = w_head.rec.addr;
    assign tr_data_o   = w_head.rec.data;
    assign fill_o      = r_cnt;
    assign drop_cnt_o  = r_drop;
    assign proto_err_o = r_perr;

endmodule

// File: tb/tb_mem_trace_recorder.sv
`timescale 1ns/1ps
// Self-checking bench for mem_trace_recorder (NUM_CH=2, DEPTH=8).
// A transaction-level reference model (queues, absolute cycle numbers) is
// stepped alongside the DUT; directed steps add fixed expected values.
module tb_mem_trace_recorder;
    localparam int NCH   = 2;
    localparam int DEPTH = 8;

    logic        clk = 1'b0, rst_n = 1'b0, en = 1'b0, ready = 1'b0;
    logic [1:0]  req, gnt, we, rvalid;
    logic [63:0] addr, wdata, rdata;

    logic        tr_valid_o, tr_we_o, proto_err_o;
    logic [0:0]  tr_ch_o;
    logic [15:0] tr_ts_o, drop_cnt_o;
    logic [7:0]  tr_lat_o;
    logic [31:0] tr_addr_o, tr_data_o;
    logic [3:0]  fill_o;

    always #5 clk = ~clk;

    mem_trace_recorder #(.NUM_CH(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(8),
                         .TS_WIDTH(16), .LAT_WIDTH(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .trace_en_i(en),
        .ch_req_i(req), .ch_gnt_i(gnt), .ch_we_i(we), .ch_addr_i(addr),
        .ch_wdata_i(wdata), .ch_rvalid_i(rvalid), .ch_rdata_i(rdata),
        .tr_valid_o(tr_valid_o), .tr_ready_i(ready), .tr_ch_o(tr_ch_o),
        .tr_ts_o(tr_ts_o), .tr_lat_o(tr_lat_o), .tr_we_o(tr_we_o),
        .tr_addr_o(tr_addr_o), .tr_data_o(tr_data_o), .fill_o(fill_o),
        .drop_cnt_o(drop_cnt_o), .proto_err_o(proto_err_o)
    );

    typedef struct packed {
        logic [0:0]  ch;
        logic [15:0] ts;
        logic [7:0]  lat;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } mrec_t;

    // Reference model state
    mrec_t       m_q[$];
    bit          m_out[NCH], m_stg[NCH], m_we[NCH];
    int          m_gcyc[NCH];
    logic [31:0] m_addr[NCH], m_wd[NCH];
    mrec_t       m_srec[NCH];
    int          m_rr, m_cyc, m_drop;
    bit          m_perr;

    int checks = 0, errors = 0;

    task automatic cmp(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        for (int c = 0; c < NCH; c++) begin
            m_out[c] = 0; m_stg[c] = 0;
        end
        m_rr = 0; m_cyc = 0; m_drop = 0; m_perr = 0;
    endtask

    task automatic model_step();
        int    win;
        bit    pop, push;
        bit    nstg[NCH];
        mrec_t nsrec[NCH];
        pop = (m_q.size() > 0) && ready;
        win = -1;
        for (int i = 0; i < NCH; i++) begin
            int c;
            c = (m_rr + i) % NCH;
            if (win < 0 && m_stg[c]) win = c;
        end
        push = (win >= 0) && ((m_q.size() < DEPTH) || pop);
        if (pop) void'(m_q.pop_front());
        if (push) begin
            m_q.push_back(m_srec[win]);
            m_rr = (win + 1) % NCH;
        end
        for (int c = 0; c < NCH; c++) begin
            bit g, rv, drained;
            g       = req[c] && gnt[c];
            rv      = rvalid[c];
            drained = push && (win == c);
            nstg[c]  = drained ? 1'b0 : m_stg[c];
            nsrec[c] = m_srec[c];
            if (rv) begin
                if (!m_out[c]) m_perr = 1;
                else begin
                    mrec_t r;
                    int    k;
                    k      = m_cyc - m_gcyc[c];
                    r.ch   = 1'(c);
                    r.ts   = 16'(m_gcyc[c]);
                    r.lat  = (k > 255) ? 8'hFF : 8'(k);
                    r.we   = m_we[c];
                    r.addr = m_addr[c];
                    r.data = m_we[c] ? m_wd[c] : rdata[c*32 +: 32];
                    if (m_stg[c] && !drained) begin
                        if (m_drop < 65535) m_drop++;
                    end else begin
                        nstg[c]  = 1;
                        nsrec[c] = r;
                    end
                end
            end
            if (g && m_out[c] && !rv) m_perr = 1;
            if (g && en && (!m_out[c] || rv)) begin
                m_out[c]  = 1;
                m_gcyc[c] = m_cyc;
                m_we[c]   = we[c];
                m_addr[c] = addr[c*32 +: 32];
                m_wd[c]   = wdata[c*32 +: 32];
            end else if (rv) m_out[c] = 0;
        end
        for (int c = 0; c < NCH; c++) begin
            m_stg[c]  = nstg[c];
            m_srec[c] = nsrec[c];
        end
        m_cyc++;
    endtask

    task automatic check_all();
        cmp("valid", 96'(tr_valid_o), 96'(m_q.size() > 0));
        cmp("fill",  96'(fill_o), 96'(m_q.size()));
        cmp("drop",  96'(drop_cnt_o), 96'(m_drop));
        cmp("perr",  96'(proto_err_o), 96'(m_perr));
        if (m_q.size() > 0)
            cmp("head", 96'({tr_ch_o, tr_ts_o, tr_lat_o, tr_we_o, tr_addr_o, tr_data_o}),
                96'(m_q[0]));
    endtask

    task automatic clr_in();
        req = '0; gnt = '0; we = '0; rvalid = '0;
        addr = '0; wdata = '0; rdata = '0;
    endtask

    task automatic issue(input int c, input bit w, input logic [31:0] a, input logic [31:0] d);
        req[c] = 1'b1; gnt[c] = 1'b1; we[c] = w;
        addr[c*32 +: 32] = a; wdata[c*32 +: 32] = d;
    endtask

    task automatic resp(input int c, input logic [31:0] d);
        rvalid[c] = 1'b1; rdata[c*32 +: 32] = d;
    endtask

    // Inputs are set between edges; the model consumes them at the edge.
    task automatic step();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        check_all();
        clr_in();
    endtask

    initial begin
        clr_in();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        cmp("rst_valid", 96'(tr_valid_o), 96'(0));
        cmp("rst_fill",  96'(fill_o), 96'(0));
        cmp("rst_drop",  96'(drop_cnt_o), 96'(0));
        cmp("rst_perr",  96'(proto_err_o), 96'(0));
        cmp("rst_data",  96'(tr_data_o), 96'(0));
        @(negedge clk);
        rst_n = 1'b1; en = 1'b1;

        // Basic read: grant at cycle 10, rvalid at 12, head valid at 14
        repeat (10) step();
        issue(0, 0, 32'h20, 32'h0); step();
        step();
        resp(0, 32'hDEADBEEF); step();
        cmp("t1_early", 96'(tr_valid_o), 96'(0));
        step();
        cmp("t1_valid", 96'(tr_valid_o), 96'(1));
        cmp("t1_rec", 96'({tr_ch_o, tr_ts_o, tr_lat_o, tr_we_o, tr_addr_o, tr_data_o}),
            96'({1'b0, 16'd10, 8'd2, 1'b0, 32'h20, 32'hDEADBEEF}));
        ready = 1'b1; step();

        // ch1 record moves the rr pointer back to 0
        issue(1, 0, 32'h30, 32'h0); step();
        resp(1, 32'h55); step();
        repeat (3) step();
        ready = 1'b0;

        // Simultaneous completions, rr=0: ch0 then ch1
        issue(0, 0, 32'h44, 32'h0);
        issue(1, 1, 32'h100, 32'h5A5A5A5A); step();
        resp(0, 32'h11112222); resp(1, 32'h0BADF00D); step();
        repeat (2) step();
        cmp("t2_fill", 96'(fill_o), 96'(2));
        cmp("t2_first_ch", 96'(tr_ch_o), 96'(0));
        cmp("t2_first_data", 96'(tr_data_o), 96'(32'h11112222));
        ready = 1'b1; step();
        cmp("t2_second", 96'({tr_ch_o, tr_we_o, tr_addr_o, tr_data_o}),
            96'({1'b1, 1'b1, 32'h100, 32'h5A5A5A5A}));
        step();
        ready = 1'b0;

        // Overflow: 10 back-to-back single-cycle reads with no consumer
        for (int i = 0; i <= 10; i++) begin
            if (i > 0)  resp(0, 32'(i));
            if (i < 10) issue(0, 0, 32'(i * 4), 32'h0);
            step();
        end
        cmp("t3_fill", 96'(fill_o), 96'(8));
        cmp("t3_drop", 96'(drop_cnt_o), 96'(1));
        ready = 1'b1; step(); ready = 1'b0;
        cmp("t3_fill_after_pop", 96'(fill_o), 96'(8));
        ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cmp("t3_order", 96'(tr_data_o), 96'(k + 2));
            step();
        end
        cmp("t3_empty", 96'(fill_o), 96'(0));
        ready = 1'b0;

        // Randomised legal traffic
        for (int n = 0; n < 400; n++) begin
            en    = ($urandom_range(0, 7) != 0);
            ready = ($urandom_range(0, 2) != 0);
            for (int c = 0; c < NCH; c++) begin
                bit rv;
                rv = m_out[c] && ($urandom_range(0, 2) == 0);
                if (rv) resp(c, $urandom);
                if ((!m_out[c] || rv) && $urandom_range(0, 1) == 1)
                    issue(c, 1'($urandom_range(0, 1)), $urandom, $urandom);
                else
                    req[c] = 1'($urandom_range(0, 1));
            end
            step();
        end
        en = 1'b1; ready = 1'b1;
        for (int c = 0; c < NCH; c++) if (m_out[c]) resp(c, 32'h0);
        step();
        repeat (12) step();
        ready = 1'b0;
        cmp("rand_perr_clean", 96'(proto_err_o), 96'(0));
        cmp("rand_drained", 96'(fill_o), 96'(0));

        // Stray rvalid
        resp(0, 32'h1234); step();
        cmp("t4_perr", 96'(proto_err_o), 96'(1));
        cmp("t4_nopush", 96'(fill_o), 96'(0));
        repeat (3) step();
        cmp("t4_sticky", 96'(proto_err_o), 96'(1));
        cmp("t4_still_empty", 96'(fill_o), 96'(0));

        // Timestamp near wrap, 300-cycle latency saturates
        while ((m_cyc & 32'hFFFF) != 32'hFFFE) step();
        issue(1, 0, 32'hABC, 32'h0); step();
        repeat (299) step();
        resp(1, 32'h77); step();
        step();
        cmp("t5_valid", 96'(tr_valid_o), 96'(1));
        cmp("t5_ts", 96'(tr_ts_o), 96'(16'hFFFE));
        cmp("t5_lat", 96'(tr_lat_o), 96'(8'hFF));
        cmp("t5_data", 96'(tr_data_o), 96'(32'h77));
        ready = 1'b1; step(); ready = 1'b0;

        // Reset with 3 FIFO entries and one outstanding
        issue(0, 0, 32'h10, 32'h0); step();
        resp(0, 32'h1); issue(0, 0, 32'h14, 32'h0); step();
        resp(0, 32'h2); issue(0, 0, 32'h18, 32'h0); step();
        resp(0, 32'h3); step();
        repeat (2) step();
        issue(1, 0, 32'h20, 32'h0); step();
        cmp("t6_pre_fill", 96'(fill_o), 96'(3));
        #2;
        rst_n = 1'b0;
        #1;
        cmp("t6_valid", 96'(tr_valid_o), 96'(0));
        cmp("t6_fill", 96'(fill_o), 96'(0));
        cmp("t6_drop", 96'(drop_cnt_o), 96'(0));
        cmp("t6_perr", 96'(proto_err_o), 96'(0));
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        resp(1, 32'h99); step();
        cmp("t6_stale_rvalid", 96'(proto_err_o), 96'(1));
        cmp("t6_no_record", 96'(fill_o), 96'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
